efm_cfg_ctrl: RTL and testbench
===============================

Name: efm_cfg_ctrl

Overview:
- Configuration sequencer for one error-feedback modulator stage.
- Accepts resolution and seed requests over a valid/ready handshake. Waits for a sample-frame boundary, then gates the stage input.
- Drives the stage's one-hot carry select, sum mask and seed. Asserts a seed-load pulse, then lets the pipelined adder settle before releasing the stage.
- Sits between the register/control interface and the modulator stage.

Parameters:
- P_DATA_WIDTH, 8: modulator accumulator width; fixes o_sum_sel width and o_cout_sel width (P_DATA_WIDTH+1).
- P_FLUSH_CYCLES, 4: cycles of input hold before and after a reconfiguration. Must be >= 1; 0 is illegal.
- P_TIMEOUT, 256: boundary-wait watchdog limit in cycles. Used only with EFM_CFG_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cfg_valid  in  1  config request valid.
- o_cfg_ready  out  1  controller can accept a request.
- i_cfg_width  in  4  requested resolution W, legal range 0..8.
- i_cfg_seed  in  8  requested accumulator seed.
- i_frame_strobe  in  1  one-cycle sample-frame boundary marker.
- i_err_clr  in  1  clears o_cfg_err.
- o_sum_sel  out  8  sum mask, (1<<W)-1.
- o_cout_sel  out  9  one-hot carry select, 1<<W.
- o_seed  out  8  seed value presented to the stage.
- o_seed_load  out  1  one-cycle reseed pulse.
- o_hold  out  1  stage input gate; 1 = datapath input forced to zero.
- o_busy  out  1  reconfiguration in progress (state != IDLE).
- o_cfg_err  out  1  sticky illegal-width flag.
- o_timeout  out  1  sticky watchdog flag. Present only with EFM_CFG_TIMEOUT_EN.

Behaviour:
- Reset, asynchronous on i_rst=1:
  - state IDLE, o_sum_sel=0xFF, o_cout_sel=0x100, o_seed=0x00.
  - o_seed_load=0, o_hold=0, o_busy=0, o_cfg_err=0, o_timeout=0.
  - Shadow width/seed = 8/0x00. Counter = 0.
- All outputs are registered. o_cfg_ready = (state==IDLE), combinational from state only.
- Handshake: a request is accepted on the edge where i_cfg_valid & o_cfg_ready.
  - Legal request (W<=8): W and seed captured into shadow registers; state becomes WAIT_EDGE.
  - Illegal request (W>8): request is consumed, o_cfg_err=1 from the next cycle, state stays IDLE, outputs unchanged.
- FSM:
  - IDLE: o_hold=0. Wait for an accepted request.
  - WAIT_EDGE: i_frame_strobe=1 sampled -> HOLD, counter loaded with P_FLUSH_CYCLES-1. A strobe in the accept cycle itself is ignored.
  - HOLD: o_hold=1. Count down; at 0 -> LOAD.
  - LOAD: exactly one cycle. o_hold=1, o_seed_load=1. o_sum_sel, o_cout_sel and o_seed carry the new shadow values in this cycle and hold them afterwards. Counter reloaded to P_FLUSH_CYCLES-1.
  - SETTLE: o_hold=1. Count down; at 0 -> IDLE.
- Timing from strobe sample at cycle s:
  - o_hold high from s+1 for 2*P_FLUSH_CYCLES+1 cycles.
  - LOAD at s+1+P_FLUSH_CYCLES.
  - o_cfg_ready returns in cycle s+2+2*P_FLUSH_CYCLES.
- Width mapping:
  - W=0: o_sum_sel=0x00, o_cout_sel=0x001 (external quantizer pass-through).
  - W=8: 0xFF / 0x100.
  - o_cout_sel is always exactly one-hot.
- i_frame_strobe is ignored outside WAIT_EDGE.
- i_cfg_valid is ignored while busy; the requester must hold its data until ready.
- o_cfg_err: set has priority over i_err_clr in the same cycle. Otherwise it clears on i_err_clr.
- Reset mid-operation: immediate return to reset values. A pending shadow config is discarded.

Optional Feature:
- Macro EFM_CFG_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles in WAIT_EDGE.
  - After P_TIMEOUT cycles with no strobe, the FSM goes to HOLD as if a strobe arrived, and sets sticky o_timeout.
  - o_timeout clears on i_err_clr, with the same set-priority rule as o_cfg_err.
  - Counter resets on entry to WAIT_EDGE.
- Not defined:
  - WAIT_EDGE waits indefinitely.
  - No o_timeout port and no watchdog logic.

Test Plan:
- Reset check: assert i_rst mid-clock -> outputs immediately 0xFF/0x100/0x00, ready=1, hold=0.
- Nominal reconfiguration: request W=3, seed=0x5A; strobe 5 cycles later, P_FLUSH_CYCLES=4.
  - o_hold high 9 cycles.
  - In LOAD: o_seed_load pulse, o_sum_sel=0x07, o_cout_sel=0x008, o_seed=0x5A.
  - Ready returns 10 cycles after the strobe sample.
- W=0 request -> o_sum_sel=0x00, o_cout_sel=0x001. Then W=8 -> 0xFF/0x100.
- Illegal W=9 -> ready stays 1, o_cfg_err=1 next cycle, outputs unchanged.
  - i_err_clr asserted together with a new W=12 request -> o_cfg_err stays 1.
- Strobe and busy corner cases:
  - Strobe coincident with the accept cycle -> ignored; sequence starts on the next strobe.
  - New valid during HOLD -> not accepted until IDLE.
- With EFM_CFG_TIMEOUT_EN, P_TIMEOUT=16, no strobe -> HOLD entered 16 cycles after WAIT_EDGE entry, o_timeout=1.
- Assert i_rst during SETTLE -> reset values, shadow discarded.

Source files
------------

// File: rtl/efm_cfg_ctrl.sv
// Configuration sequencer for one error-feedback modulator stage: frame-aligned hold, reseed, settle.
// Optional boundary-wait watchdog and o_timeout port enabled by defining EFM_CFG_TIMEOUT_EN.
module efm_cfg_ctrl #(
  parameter int unsigned P_DATA_WIDTH   = 8,
  parameter int unsigned P_FLUSH_CYCLES = 4,
  parameter int unsigned P_TIMEOUT      = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [3:0]              i_cfg_width,
  input  logic [P_DATA_WIDTH-1:0] i_cfg_seed,
  input  logic                    i_frame_strobe,
  input  logic                    i_err_clr,
  output logic [P_DATA_WIDTH-1:0] o_sum_sel,
  output logic [P_DATA_WIDTH:0]   o_cout_sel,
  output logic [P_DATA_WIDTH-1:0] o_seed,
  output logic                    o_seed_load,
  output logic                    o_hold,
  output logic                    o_busy,
  output logic                    o_cfg_err
`ifdef EFM_CFG_TIMEOUT_EN
  ,
  output logic                    o_timeout
`endif
);

  localparam int unsigned CoutW = P_DATA_WIDTH + 1;
  localparam int unsigned CntW  = (P_FLUSH_CYCLES > 1) ? $clog2(P_FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(P_FLUSH_CYCLES - 1);

  if (P_FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("P_FLUSH_CYCLES must be at least 1");
  end
  if (P_TIMEOUT < 1) begin : g_bad_timeout
    $error("P_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StWaitEdge, StHold, StLoad, StSettle} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [3:0]              width_q, width_d;
  logic [P_DATA_WIDTH-1:0] shadow_seed_q, shadow_seed_d;
  logic [P_DATA_WIDTH-1:0] sum_q, sum_d;
  logic [CoutW-1:0]        cout_q, cout_d;
  logic [P_DATA_WIDTH-1:0] seed_q, seed_d;
  logic                    seed_load_q, seed_load_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    accept, legal, edge_go;
  logic [CoutW-1:0]        cout_new, sum_full;

  assign accept   = i_cfg_valid && (state_q == StIdle);
  assign legal    = 32'(i_cfg_width) <= P_DATA_WIDTH;
  assign cout_new = CoutW'(1) << width_q;
  assign sum_full = cout_new - CoutW'(1);

`ifdef EFM_CFG_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(P_TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_expire;
  logic           timeout_q, timeout_d;

  assign wd_expire = (state_q == StWaitEdge) && (wd_q == WdW'(P_TIMEOUT - 1));
  // Counter is zero on every entry to StWaitEdge since it is cleared in all other states.
  assign wd_d      = (state_q == StWaitEdge) ? wd_q + WdW'(1) : '0;

  always_comb begin
    timeout_d = timeout_q;
    if (i_err_clr) timeout_d = 1'b0;
    if (wd_expire && !i_frame_strobe) timeout_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
  assign edge_go   = i_frame_strobe || wd_expire;
`else
  assign edge_go   = i_frame_strobe;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    width_d       = width_q;
    shadow_seed_d = shadow_seed_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    seed_d        = seed_q;
    err_d         = err_q;
    if (i_err_clr) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (legal) begin
            width_d       = i_cfg_width;
            shadow_seed_d = i_cfg_seed;
            state_d       = StWaitEdge;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWaitEdge: begin
        if (edge_go) begin
          state_d = StHold;
          cnt_d   = CntLoad;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          // New mapping lands on the outputs in the LOAD cycle itself.
          state_d = StLoad;
          sum_d   = sum_full[P_DATA_WIDTH-1:0];
          cout_d  = cout_new;
          seed_d  = shadow_seed_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StLoad: begin
        state_d = StSettle;
        cnt_d   = CntLoad;
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    hold_d      = (state_d == StHold) || (state_d == StLoad) || (state_d == StSettle);
    seed_load_d = (state_d == StLoad);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      width_q       <= 4'(P_DATA_WIDTH);
      shadow_seed_q <= '0;
      sum_q         <= '1;
      cout_q        <= CoutW'(1) << P_DATA_WIDTH;
      seed_q        <= '0;
      seed_load_q   <= 1'b0;
      hold_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      shadow_seed_q <= shadow_seed_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      seed_q        <= seed_d;
      seed_load_q   <= seed_load_d;
      hold_q        <= hold_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign o_cfg_ready = (state_q == StIdle);
  assign o_sum_sel   = sum_q;
  assign o_cout_sel  = cout_q;
  assign o_seed      = seed_q;
  assign o_seed_load = seed_load_q;
  assign o_hold      = hold_q;
  assign o_busy      = busy_q;
  assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_efm_cfg_ctrl.sv
// Directed self-checking bench for efm_cfg_ctrl with P_FLUSH_CYCLES=4, P_TIMEOUT=16.
// Timeout steps are compiled in when EFM_CFG_TIMEOUT_EN is defined.
module tb_efm_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_width = 4'd0;
  logic [7:0] cfg_seed = 8'd0;
  logic       frame_strobe = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] sum_sel;
  logic [8:0] cout_sel;
  logic [7:0] seed;
  logic       seed_load;
  logic       hold;
  logic       busy;
  logic       cfg_err;
`ifdef EFM_CFG_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  efm_cfg_ctrl #(
    .P_DATA_WIDTH  (8),
    .P_FLUSH_CYCLES(4),
    .P_TIMEOUT     (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_width   (cfg_width),
    .i_cfg_seed    (cfg_seed),
    .i_frame_strobe(frame_strobe),
    .i_err_clr     (err_clr),
    .o_sum_sel     (sum_sel),
    .o_cout_sel    (cout_sel),
    .o_seed        (seed),
    .o_seed_load   (seed_load),
    .o_hold        (hold),
    .o_busy        (busy),
    .o_cfg_err     (cfg_err)
`ifdef EFM_CFG_TIMEOUT_EN
    ,
    .o_timeout     (timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [7:0] es, input logic [8:0] ec,
                                  input logic [7:0] ed);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sload"}, 32'(seed_load), 32'd0);
    chk({tag, "_sum"}, 32'(sum_sel), 32'(es));
    chk({tag, "_cout"}, 32'(cout_sel), 32'(ec));
    chk({tag, "_seed"}, 32'(seed), 32'(ed));
  endtask

  // Called in WAIT_EDGE; strobe sampled at the next edge (cycle s).
  task automatic run_seq(input string tag, input logic [7:0] es, input logic [8:0] ec,
                         input logic [7:0] ed, input bit inject);
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk({tag, "_hold"}, 32'(hold), 32'd1);
      chk({tag, "_ready_low"}, 32'(cfg_ready), 32'd0);
      if (i == 5) begin
        chk({tag, "_load_pulse"}, 32'(seed_load), 32'd1);
        chk({tag, "_load_sum"}, 32'(sum_sel), 32'(es));
        chk({tag, "_load_cout"}, 32'(cout_sel), 32'(ec));
        chk({tag, "_load_seed"}, 32'(seed), 32'(ed));
      end else begin
        chk({tag, "_no_pulse"}, 32'(seed_load), 32'd0);
      end
      if (inject && i == 2) begin
        cfg_valid = 1'b1;
        cfg_width = 4'd0;
        cfg_seed  = 8'h11;
      end
      tick();
    end
    chk_idle_outputs({tag, "_done"}, es, ec, ed);
  endtask

  initial begin
    // Reset state
    #12;
    chk_idle_outputs("reset", 8'hFF, 9'h100, 8'h00);
    chk("reset_err", 32'(cfg_err), 32'd0);
`ifdef EFM_CFG_TIMEOUT_EN
    chk("reset_timeout", 32'(timeout), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Nominal W=3 seed=0x5A; a new request is raised during HOLD (must wait for IDLE)
    cfg_valid = 1'b1;
    cfg_width = 4'd3;
    cfg_seed  = 8'h5A;
    tick();
    cfg_valid = 1'b0;
    chk("nom_accept_busy", 32'(busy), 32'd1);
    chk("nom_accept_ready", 32'(cfg_ready), 32'd0);
    chk("nom_accept_sum", 32'(sum_sel), 32'hFF);
    for (int i = 0; i < 4; i++) begin
      chk("nom_wait_hold", 32'(hold), 32'd0);
      tick();
    end
    run_seq("nom", 8'h07, 9'h008, 8'h5A, 1'b1);

    // Held W=0 request now accepted; strobe on first WAIT_EDGE cycle
    tick();
    cfg_valid = 1'b0;
    chk("w0_accept_busy", 32'(busy), 32'd1);
    run_seq("w0", 8'h00, 9'h001, 8'h11, 1'b0);

    // W=8 with strobe coincident with accept: strobe must be ignored
    cfg_valid    = 1'b1;
    cfg_width    = 4'd8;
    cfg_seed     = 8'hC3;
    frame_strobe = 1'b1;
    tick();
    cfg_valid    = 1'b0;
    frame_strobe = 1'b0;
    chk("w8_accept_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("w8_coinc_strobe_hold", 32'(hold), 32'd0);
      tick();
    end
    run_seq("w8", 8'hFF, 9'h100, 8'hC3, 1'b0);

    // Illegal W=9: consumed, error flagged, outputs unchanged
    cfg_valid = 1'b1;
    cfg_width = 4'd9;
    cfg_seed  = 8'h99;
    tick();
    cfg_valid = 1'b0;
    chk("ill_err_set", 32'(cfg_err), 32'd1);
    chk_idle_outputs("ill", 8'hFF, 9'h100, 8'hC3);
    // Clear together with a new illegal W=12: set wins
    cfg_valid = 1'b1;
    cfg_width = 4'd12;
    err_clr   = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("ill_set_priority", 32'(cfg_err), 32'd1);
    chk("ill_w12_ready", 32'(cfg_ready), 32'd1);
    tick();
    err_clr = 1'b0;
    chk("ill_err_cleared", 32'(cfg_err), 32'd0);

    // Reset during SETTLE
    cfg_valid = 1'b1;
    cfg_width = 4'd2;
    cfg_seed  = 8'h3C;
    tick();
    cfg_valid    = 1'b0;
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("settle_hold", 32'(hold), 32'd1);
    chk("settle_busy", 32'(busy), 32'd1);
    chk("settle_sum", 32'(sum_sel), 32'h03);
    chk("settle_cout", 32'(cout_sel), 32'h004);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrst", 8'hFF, 9'h100, 8'h00);
    chk("midrst_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    tick();
    chk_idle_outputs("post_rst", 8'hFF, 9'h100, 8'h00);

`ifdef EFM_CFG_TIMEOUT_EN
    // Watchdog: no strobe, HOLD entered 16 cycles after WAIT_EDGE entry
    cfg_valid = 1'b1;
    cfg_width = 4'd5;
    cfg_seed  = 8'h77;
    tick();
    cfg_valid = 1'b0;
    chk("wd_entry_hold", 32'(hold), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("wd_wait_hold", 32'(hold), 32'd0);
      chk("wd_wait_timeout", 32'(timeout), 32'd0);
    end
    tick();
    chk("wd_fire_hold", 32'(hold), 32'd1);
    chk("wd_fire_timeout", 32'(timeout), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk_idle_outputs("wd_done", 8'h1F, 9'h020, 8'h77);
    chk("wd_sticky", 32'(timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_cleared", 32'(timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
